// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encoding,
// RV32I major opcodes, ALU operation codes and writeback-source selects.
package multicycle_control_unit_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        R_EXE,
        I_EXE,
        B_EXE,
        LU_EXE,
        AU_EXE,
        J_EXE,
        JL_EXE,
        S_EXE,
        S_MEM,
        L_EXE,
        L_MEM,
        L_WB,
        TRAP
    } state_e;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_LU = 7'b0110111;
    localparam logic [6:0] OP_AU = 7'b0010111;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JL = 7'b1100111;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_L  = 7'b0000011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [2:0] RFWD_ALU    = 3'd0;
    localparam logic [2:0] RFWD_LOAD   = 3'd1;
    localparam logic [2:0] RFWD_IMM    = 3'd2;
    localparam logic [2:0] RFWD_PC_IMM = 3'd3;
    localparam logic [2:0] RFWD_PC_4   = 3'd4;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU operation decoder for the multicycle control unit.
// Ports:
//   state_i       current FSM state
//   funct3_i      instruction funct3 field
//   funct7_5_i    instruction bit 30 (funct7[5])
//   alu_control_o ALU operation / branch-compare select
module multicycle_control_unit_alu_decoder
    import multicycle_control_unit_pkg::*;
(
    input  state_e     state_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [3:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (state_i)
            R_EXE:   alu_control_o = {funct7_5_i, funct3_i};
            // Bit 30 is part of the immediate for I-type, except for the
            // shift-right pair where it selects SRA over SRL.
            I_EXE:   alu_control_o = {(funct3_i == 3'b101) ? funct7_5_i : 1'b0, funct3_i};
            B_EXE:   alu_control_o = {1'b0, funct3_i};
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch, decode and
// per-class execute/memory/writeback steps.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   instrCode       current instruction word
//   regFileWe       register-file write enable
//   aluControl      ALU operation / branch-compare select
//   aluSrcMuxSel    ALU operand B: 0=rs2, 1=immediate
//   RFWDSrcMuxSel   writeback source: 0=ALU,1=load,2=imm,3=PC+imm,4=PC+4
//   branch/jal/jalr PC-source qualifiers
//   PCEn            PC load enable
//   busWe           data-bus write strobe
//   illegalInstr    unsupported-opcode flag
// Build option: CTRL_ILLEGAL_TRAP_EN routes unlisted opcodes to TRAP;
// otherwise they retire as a NOP.
//
// state  | meaning
// FETCH  | PC advances, instruction word becomes valid
// DECODE | opcode dispatch
// R_EXE  | reg-reg ALU op, writeback
// I_EXE  | reg-imm ALU op, writeback
// B_EXE  | branch compare
// LU_EXE | LUI writeback
// AU_EXE | AUIPC writeback
// J_EXE  | JAL target + link
// JL_EXE | JALR target + link
// S_EXE  | store address
// S_MEM  | store bus write
// L_EXE  | load address
// L_MEM  | load bus read
// L_WB   | load writeback
// TRAP   | illegal opcode, held until reset
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
    output logic        regFileWe,
    output logic [3:0]  aluControl,
    output logic        aluSrcMuxSel,
    output logic [2:0]  RFWDSrcMuxSel,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic        PCEn,
    output logic        busWe,
    output logic        illegalInstr
);

    state_e state_q, state_d;

    logic [6:0] opcode;
    assign opcode = instrCode[6:0];

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

    multicycle_control_unit_alu_decoder u_alu_decoder (
        .state_i       (state_q),
        .funct3_i      (instrCode[14:12]),
        .funct7_5_i    (instrCode[30]),
        .alu_control_o (aluControl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        regFileWe     = 1'b0;
        aluSrcMuxSel  = 1'b0;
        RFWDSrcMuxSel = RFWD_ALU;
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        PCEn          = 1'b0;
        busWe         = 1'b0;
        illegalInstr  = 1'b0;
        case (state_q)
            FETCH: begin
                PCEn    = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_R:    state_d = R_EXE;
                    OP_I:    state_d = I_EXE;
                    OP_B:    state_d = B_EXE;
                    OP_LU:   state_d = LU_EXE;
                    OP_AU:   state_d = AU_EXE;
                    OP_J:    state_d = J_EXE;
                    OP_JL:   state_d = JL_EXE;
                    OP_S:    state_d = S_EXE;
                    OP_L:    state_d = L_EXE;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default: state_d = TRAP;
`else
                    default: state_d = FETCH;
`endif
                endcase
            end
            R_EXE: begin
                regFileWe = 1'b1;
                state_d   = FETCH;
            end
            I_EXE: begin
                regFileWe    = 1'b1;
                aluSrcMuxSel = 1'b1;
                state_d      = FETCH;
            end
            B_EXE: begin
                branch  = 1'b1;
                state_d = FETCH;
            end
            LU_EXE: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = RFWD_IMM;
                state_d       = FETCH;
            end
            AU_EXE: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = RFWD_PC_IMM;
                state_d       = FETCH;
            end
            J_EXE: begin
                jal           = 1'b1;
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = RFWD_PC_4;
                state_d       = FETCH;
            end
            JL_EXE: begin
                jal           = 1'b1;
                jalr          = 1'b1;
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = RFWD_PC_4;
                state_d       = FETCH;
            end
            S_EXE: begin
                aluSrcMuxSel = 1'b1;
                state_d      = S_MEM;
            end
            S_MEM: begin
                aluSrcMuxSel = 1'b1;
                busWe        = 1'b1;
                state_d      = FETCH;
            end
            L_EXE: begin
                aluSrcMuxSel = 1'b1;
                state_d      = L_MEM;
            end
            L_MEM: begin
                aluSrcMuxSel = 1'b1;
                state_d      = L_WB;
            end
            L_WB: begin
                aluSrcMuxSel  = 1'b1;
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = RFWD_LOAD;
                state_d       = FETCH;
            end
            TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                illegalInstr = 1'b1;
                state_d      = TRAP;
`else
                state_d      = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port instrCode  input  32  current instruction word from instruction memory (addressed by PC).
REQ-004 SHALL have port regFileWe  output  1  register-file write enable.
REQ-005 SHALL have port aluControl  output  4  ALU operation / branch-compare select.
REQ-006 SHALL have port aluSrcMuxSel  output  1  ALU operand B: 0=rs2 data, 1=immediate.
REQ-007 SHALL have port RFWDSrcMuxSel  output  3  writeback source: 0=ALU, 1=load data, 2=imm, 3=PC+imm, 4=PC+4.
REQ-008 SHALL have ports branch, jal, jalr  output  1 each  PC-source qualifiers.
REQ-009 SHALL have port PCEn  output  1  PC register load enable.
REQ-010 SHALL have port busWe  output  1  data-bus write strobe.
REQ-011 SHALL have port illegalInstr  output  1  unsupported-opcode flag (see Configuration).

Function
REQ-012 SHALL implement a Moore FSM; only the state register is sequential; outputs SHALL be combinational from state and instrCode.
REQ-013 States SHALL be FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP.
REQ-014 FETCH: PCEn=1, all other outputs 0; next state DECODE unconditionally.
REQ-015 DECODE: all outputs 0; next state selected by opcode: R 0110011, I 0010011, B 1100011, LU 0110111, AU 0010111, J 1101111, JL 1100111, S 0100011, L 0000011.
REQ-016 R_EXE, I_EXE, LU_EXE, AU_EXE, B_EXE, J_EXE, JL_EXE, S_MEM, L_WB SHALL return to FETCH; S_EXE->S_MEM; L_EXE->L_MEM->L_WB.
REQ-017 Per-class cycles from FETCH to next FETCH: R/I/B/LU/AU/J/JL=3, S=4, L=5.
REQ-018 aluControl encoding: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111; branch compare uses [2:0]=funct3.
REQ-019 R_EXE: aluControl={instr[30],funct3}, regFileWe=1, RFWD=0, aluSrc=0.
REQ-020 I_EXE: aluControl={(funct3==101)?instr[30]:0, funct3}, aluSrc=1, regFileWe=1, RFWD=0.
REQ-021 B_EXE: aluControl={0,funct3}, aluSrc=0, branch=1, regFileWe=0.
REQ-022 LU_EXE: regFileWe=1, RFWD=2; AU_EXE: regFileWe=1, RFWD=3, jalr=0.
REQ-023 J_EXE: jal=1, regFileWe=1, RFWD=4; JL_EXE: jal=1, jalr=1, regFileWe=1, RFWD=4.
REQ-024 S_EXE, S_MEM, L_EXE, L_MEM, L_WB: aluControl=ADD, aluSrc=1; busWe=1 only in S_MEM; L_WB regFileWe=1, RFWD=1.
REQ-025 branch/jal/jalr SHALL be 0 outside their EXE state, so PC target defaults to PC+4.
REQ-026 regFileWe and busWe SHALL never be 1 in the same cycle nor in FETCH/DECODE.

Reset
REQ-027 Reset asserted SHALL force state FETCH immediately, regardless of current state (incl. TRAP, S_MEM mid-store).
REQ-028 During and right after reset outputs SHALL be FETCH values: PCEn=1, all others 0, illegalInstr=0.

Configuration
REQ-029 Macro CTRL_ILLEGAL_TRAP_EN defined: unlisted opcode in DECODE SHALL go to TRAP; TRAP holds until reset, illegalInstr=1, PCEn=0, all write enables 0.
REQ-030 Macro undefined: unlisted opcode SHALL go DECODE->FETCH as a NOP (PC advances by 4), TRAP unreachable, illegalInstr tied 0.

Structure
REQ-031 Shared package SHALL hold state enum, opcode constants, aluControl constants, RFWD select constants.
REQ-032 One sub-module alu_decoder (funct3/funct7[5]/state -> aluControl) is natural; FSM stays in top.

Verification
REQ-033 Reset, release, instrCode=0x002081B3 (add x3,x1,x2) -> FETCH,DECODE,R_EXE; regFileWe=1, aluControl=0000, RFWD=0 in cycle 3 only.
REQ-034 instrCode=0x0020A223 (sw) -> 4 cycles; busWe=1 only in S_MEM, aluSrc=1, regFileWe never 1.
REQ-035 instrCode=0x0000A183 (lw) -> 5 cycles; regFileWe=1, RFWD=1 only in L_WB.
REQ-036 instrCode=0x00208463 (beq) -> branch=1, aluControl=0000 in B_EXE; 0x000080E7 (jalr) -> jal=1, jalr=1, RFWD=4.
REQ-037 instrCode=0xFFFFFFFF with CTRL_ILLEGAL_TRAP_EN -> TRAP, illegalInstr=1, PCEn=0 held; without -> back to FETCH after DECODE.
REQ-038 Assert reset during S_MEM -> busWe drops to 0 same cycle, state FETCH, PCEn=1.
